// File: rtl/man_input_streamer.sv
// ---------------------------------------------------------------------------
// man_input_streamer
// Streams the register-file words out over an AXI-Stream master port, one
// frame of NUM_WORDS words per repetition, num_frames repetitions per start.
//
// Ports
//   ACLK           clock, all logic on the rising edge
//   ARESETN        asynchronous active-low reset
//   reg_words      register-file contents, word k at [W*k +: W]
//   start          single-cycle request, ignored while busy
//   num_frames     frames per request, sampled on the accepted start
//   m_axis_tdata   stream data (word[index] while sending, else 0)
//   m_axis_tvalid  stream valid, high in SEND
//   m_axis_tready  stream ready from the sink
//   m_axis_tlast   high on the last word of every frame
//   busy           high in SEND and DONE
//   done           one-cycle completion pulse
//
// Build option
//   MAN_INPUT_STREAMER_SNAPSHOT_EN  when defined, reg_words is copied into a
//   shadow register on the accepted start and every frame of that request is
//   sent from the copy. When undefined, data is read live from reg_words.
// ---------------------------------------------------------------------------
module man_input_streamer #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_WORDS          = 4
) (
   input  logic                                    ACLK,
   input  logic                                    ARESETN,
   input  logic [NUM_WORDS*C_S_AXI_DATA_WIDTH-1:0] reg_words,
   input  logic                                    start,
   input  logic [7:0]                              num_frames,
   output logic [C_S_AXI_DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                                    m_axis_tvalid,
   input  logic                                    m_axis_tready,
   output logic                                    m_axis_tlast,
   output logic                                    busy,
   output logic                                    done
);

   localparam int W     = C_S_AXI_DATA_WIDTH;
   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(NUM_WORDS - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] word_idx;
   logic [7:0]       frames_left;
   logic             valid_q;
   logic             last_q;
   logic             busy_q;
   logic             done_q;

   logic [NUM_WORDS*W-1:0] data_src;
   logic [W-1:0]           word_arr [NUM_WORDS];

`ifdef MAN_INPUT_STREAMER_SNAPSHOT_EN
   // Shadow copy of the register file, taken on the accepted start so a
   // request is immune to software rewriting the registers mid-stream.
   logic [NUM_WORDS*W-1:0] shadow_words;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         shadow_words <= '0;
      end else if (state == IDLE && start) begin
         shadow_words <= reg_words;
      end
   end

   assign data_src = shadow_words;
`else
   // Without the shadow copy the stream reads the register file directly,
   // so a rewrite shows up on the next beat presented.
   assign data_src = reg_words;
`endif

   // Slice the flat register vector into addressable words.
   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
      assign word_arr[k] = data_src[k*W +: W];
   end

   // Main sequencer. Valid, last, busy and done are flops updated alongside
   // the state so the stream handshake outputs come straight from registers.
   // The word index only moves on an accepted beat, which keeps tdata and
   // tlast parked while the sink stalls.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= IDLE;
         word_idx    <= '0;
         frames_left <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy_q   <= 1'b1;
                  word_idx <= '0;
                  if (num_frames != 8'd0) begin
                     state       <= SEND;
                     frames_left <= num_frames;
                     valid_q     <= 1'b1;
                     last_q      <= (NUM_WORDS == 1);
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (m_axis_tready) begin
                  if (word_idx == LAST_IDX) begin
                     word_idx    <= '0;
                     frames_left <= frames_left - 8'd1;
                     if (frames_left == 8'd1) begin
                        state   <= DONE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        last_q <= (NUM_WORDS == 1);
                     end
                  end else begin
                     word_idx <= word_idx + 1'b1;
                     last_q   <= (word_idx == PRE_LAST_IDX);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis_tdata  = valid_q ? word_arr[word_idx] : '0;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_man_input_streamer.sv
// ---------------------------------------------------------------------------
// tb_man_input_streamer
// Self-checking bench for man_input_streamer (default parameters). The
// reference model is the plain rule "beat n of a request carries word
// (n mod NUM_WORDS), with tlast when that word is the last one, and a request
// of F frames carries exactly F*NUM_WORDS beats followed by one done pulse".
// Build option MAN_INPUT_STREAMER_SNAPSHOT_EN selects whether the model reads
// the words captured at start or the live register values.
// ---------------------------------------------------------------------------
module tb_man_input_streamer;

   localparam int W = 32;
   localparam int N = 4;

   logic           clock;
   logic           resetN;
   logic [N*W-1:0] regWords;
   logic           start;
   logic [7:0]     numFrames;
   logic [W-1:0]   tdata;
   logic           tvalid;
   logic           tready;
   logic           tlast;
   logic           busy;
   logic           done;

   int             checkCount;
   int             errorCount;
   logic [N*W-1:0] snapWords;
   logic [W-1:0]   beatLog [$];

   man_input_streamer #(
      .C_S_AXI_DATA_WIDTH (W),
      .NUM_WORDS          (N)
   ) dut (
      .ACLK          (clock),
      .ARESETN       (resetN),
      .reg_words     (regWords),
      .start         (start),
      .num_frames    (numFrames),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .busy          (busy),
      .done          (done)
   );

   // Free-running 100 MHz clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the design wedges somewhere a bounded wait cannot see.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected to be finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison goes through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [W-1:0] wordOf(input logic [N*W-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   // Runs one request and checks every presented beat against the model.
   // readyMode: 0 = always ready, 1 = toggle starting high, 2 = random.
   task automatic applyStimulus(input int frames, input int readyMode,
                                input bit injectStart, input bit changeWord);
      int           beats;
      int           cycles;
      int           budget;
      int           idx;
      bit           finished;
      bit           prevStall;
      logic [W-1:0] prevData;
      logic [W-1:0] expData;

      beatLog.delete();
      @(negedge clock);
      start     = 1'b1;
      numFrames = frames[7:0];
      snapWords = regWords;
      @(negedge clock);
      start = 1'b0;

      if (frames == 0) begin
         #1;
         checkOutput("zeroValid", W'(tvalid), 0);
         checkOutput("zeroBusy", W'(busy), 1);
         checkOutput("zeroDone", W'(done), 1);
         @(negedge clock);
         #1;
         checkOutput("zeroBusyAfter", W'(busy), 0);
         checkOutput("zeroDoneAfter", W'(done), 0);
         checkOutput("zeroValidAfter", W'(tvalid), 0);
         return;
      end

      budget    = 4 * frames * N + 20;
      beats     = 0;
      cycles    = 0;
      finished  = 1'b0;
      prevStall = 1'b0;
      prevData  = '0;
      while (!finished && cycles < budget) begin
         if (cycles > 0) @(negedge clock);
         start = (injectStart && beats == 2);
         if (changeWord && beats == 1) regWords[2*W +: W] = 32'hAA;
         case (readyMode)
            0:       tready = 1'b1;
            1:       tready = (cycles % 2 == 0);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         cycles++;
         if (done) begin
            finished = 1'b1;
            checkOutput("beatTotal", beats, frames * N);
            checkOutput("validInDone", W'(tvalid), 0);
            checkOutput("busyInDone", W'(busy), 1);
         end else begin
            checkOutput("validInSend", W'(tvalid), 1);
            checkOutput("busyInSend", W'(busy), 1);
            idx = beats % N;
`ifdef MAN_INPUT_STREAMER_SNAPSHOT_EN
            expData = wordOf(snapWords, idx);
`else
            expData = wordOf(regWords, idx);
`endif
            checkOutput("beatData", tdata, expData);
            checkOutput("beatLast", W'(tlast), W'(idx == N - 1));
            if (prevStall) checkOutput("stallStable", tdata, prevData);
            prevStall = tvalid && !tready;
            prevData  = tdata;
            if (tvalid && tready) begin
               beatLog.push_back(tdata);
               beats++;
            end
         end
      end
      start = 1'b0;
      if (!finished) checkOutput("doneTimeout", 0, 1);
      if (finished && readyMode == 0) checkOutput("cycleCount", cycles, frames * N + 1);
      @(negedge clock);
      #1;
      checkOutput("donePulseWidth", W'(done), 0);
      checkOutput("busyIdle", W'(busy), 0);
      checkOutput("validIdle", W'(tvalid), 0);
   endtask

   // Pulls reset low two beats into a four-beat frame and confirms the
   // outputs drop at once and no done pulse follows.
   task automatic resetMidFrame();
      int doneSeen;
      regWords = {32'd4, 32'd3, 32'd2, 32'd1};
      tready   = 1'b1;
      @(negedge clock);
      start     = 1'b1;
      numFrames = 8'd1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      checkOutput("preResetData", tdata, 32'd3);
      #1;
      resetN = 1'b0;
      #1;
      checkOutput("resetValid", W'(tvalid), 0);
      checkOutput("resetBusy", W'(busy), 0);
      checkOutput("resetData", tdata, 0);
      checkOutput("resetLast", W'(tlast), 0);
      checkOutput("resetDone", W'(done), 0);
      @(negedge clock);
      resetN   = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("noDoneAfterReset", doneSeen, 0);
      applyStimulus(1, 0, 1'b0, 1'b0);
      checkOutput("restartWord0", (beatLog.size() > 0) ? beatLog[0] : 32'hDEAD, 32'd1);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      resetN     = 1'b0;
      start      = 1'b0;
      numFrames  = 8'd0;
      tready     = 1'b0;
      regWords   = {32'd4, 32'd3, 32'd2, 32'd1};

      #12;
      checkOutput("rstValid", W'(tvalid), 0);
      checkOutput("rstLast", W'(tlast), 0);
      checkOutput("rstData", tdata, 0);
      checkOutput("rstBusy", W'(busy), 0);
      checkOutput("rstDone", W'(done), 0);
      @(negedge clock);
      resetN = 1'b1;

      $display("[TB] single frame, always ready");
      applyStimulus(1, 0, 1'b0, 1'b0);

      $display("[TB] three frames, toggling ready");
      applyStimulus(3, 1, 1'b0, 1'b0);
      checkOutput("toggleBeat8", (beatLog.size() > 7) ? beatLog[7] : 32'hDEAD, 32'd4);

      $display("[TB] zero frames");
      applyStimulus(0, 0, 1'b0, 1'b0);

      $display("[TB] start while busy");
      applyStimulus(2, 2, 1'b1, 1'b0);

      $display("[TB] register rewrite during send");
      applyStimulus(1, 0, 1'b0, 1'b1);
`ifdef MAN_INPUT_STREAMER_SNAPSHOT_EN
      checkOutput("rewriteBeat3", (beatLog.size() > 2) ? beatLog[2] : 32'hDEAD, 32'd3);
`else
      checkOutput("rewriteBeat3", (beatLog.size() > 2) ? beatLog[2] : 32'hDEAD, 32'hAA);
`endif
      regWords = {32'd4, 32'd3, 32'd2, 32'd1};

      $display("[TB] reset mid frame");
      resetMidFrame();

      $display("[TB] 255 frames");
      applyStimulus(255, 0, 1'b0, 1'b0);

      $display("[TB] randomized requests");
      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < N; k++) regWords[k*W +: W] = $urandom;
         applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
